alu_result_stage: RTL and testbench

- Registered output stage directly downstream of the 16-bit combinational ALU.
- Captures the ALU result O, CARRY and the opcode SEL that produced it.
- Derives status flags and buffers entries in a small FIFO with valid/ready handshakes on both sides, decoupling the ALU from the consumer (writeback / flag logic).
- Also keeps a sticky carry flag for multi-word software sequences.

---
 rtl/alu_result_stage.sv | 110 +++++++++++
 tb/tb_alu_result_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// ALU result stage: registers ALU result, opcode and derived {C,Z,N} flags
// into a valid/ready FIFO of DEPTH entries and keeps a sticky carry flag.
//
// Ports:
//   CLK, RST_N           clock, async active-low reset
//   IN_VALID/IN_READY    ALU-side handshake; SEL, O[15:0], CARRY captured on push
//   OUT_VALID/OUT_READY  consumer-side handshake; RES, OUT_SEL, FLAGS show head
//   COUNT                occupied entries, 0..DEPTH
//   CLR_STICKY/STICKY_C  sticky carry clear / status
module alu_result_stage #(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [2:0]    SEL,
  input  logic [16:0]   O,
  input  logic          CARRY,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [15:0]   RES,
  output logic [2:0]    OUT_SEL,
  output logic [2:0]    FLAGS,
  output logic [CW-1:0] COUNT,
  input  logic          CLR_STICKY,
  output logic          STICKY_C
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [15:0] res;
    logic [2:0]  sel;
    logic [2:0]  flg;
  } ent_t;

  ent_t          mem [DEPTH];
  ent_t          din;
  ent_t          head;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          sticky;
  logic          push;
  logic          pop;
  logic          cflag;
  logic          unused_o16;

  assign unused_o16 = O[16];

  // Only add/sub-class opcodes produce a meaningful carry.
  assign cflag = CARRY & ((SEL == 3'b011) | SEL[2]);

  assign din.res = O[15:0];
  assign din.sel = SEL;
  assign din.flg = {cflag, (O[15:0] == 16'h0000), O[15]};

  assign IN_READY  = (count != CW'(DEPTH));
  assign OUT_VALID = (count != '0);
  assign push      = IN_VALID & IN_READY;
  assign pop       = OUT_VALID & OUT_READY;

  // Head is forced to zero while empty so stale slots never leak out.
  assign head    = OUT_VALID ? mem[rptr] : '0;
  assign RES     = head.res;
  assign OUT_SEL = head.sel;
  assign FLAGS   = head.flg;
  assign COUNT   = count;
  assign STICKY_C = sticky;

  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A carry-setting push takes priority over a same-cycle clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sticky <= 1'b0;
    end else if (push && cflag) begin
      sticky <= 1'b1;
    end else if (CLR_STICKY) begin
      sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: flag vector table,
// hand-written corner sequences and randomized traffic vs. a queue model.
module tb_alu_result_stage;

  localparam int DEPTH = 4;
  localparam int CW = 3;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [2:0]    SEL = '0;
  logic [16:0]   O = '0;
  logic          CARRY = 1'b0;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b0;
  logic [15:0]   RES;
  logic [2:0]    OUT_SEL;
  logic [2:0]    FLAGS;
  logic [CW-1:0] COUNT;
  logic          CLR_STICKY = 1'b0;
  logic          STICKY_C;

  alu_result_stage #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .SEL(SEL), .O(O), .CARRY(CARRY),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .RES(RES), .OUT_SEL(OUT_SEL), .FLAGS(FLAGS),
    .COUNT(COUNT), .CLR_STICKY(CLR_STICKY), .STICKY_C(STICKY_C)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [15:0] res;
    logic [2:0]  sel;
    logic [2:0]  flg;
  } ent_t;

  typedef struct {
    logic [2:0]  sel;
    logic [16:0] o;
    logic        carry;
    logic [15:0] exp_res;
    logic [2:0]  exp_flg;
    logic        exp_sticky;
  } vec_t;

  ent_t q[$];
  bit   sticky_m;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ent_t model_ent(input logic [2:0] s,
                                     input logic [16:0] o,
                                     input logic c);
    ent_t e;
    int v;
    v = int'(o) % 65536;
    e.res = 16'(v);
    e.sel = s;
    e.flg[2] = c && (s == 3 || s >= 4);
    e.flg[1] = (v == 0);
    e.flg[0] = (v >= 32768);
    return e;
  endfunction

  task automatic check_all(input string tag);
    ent_t h;
    h = (q.size() != 0) ? q[0] : '0;
    chk({tag, " out_valid"}, 32'(OUT_VALID), 32'(q.size() != 0));
    chk({tag, " count"}, 32'(COUNT), q.size());
    chk({tag, " in_ready"}, 32'(IN_READY), 32'(q.size() < DEPTH));
    chk({tag, " head"}, 32'({RES, OUT_SEL, FLAGS}), 32'(h));
    chk({tag, " sticky"}, 32'(STICKY_C), 32'(sticky_m));
  endtask

  // Apply one cycle of inputs; model updates at the edge, check after it.
  task automatic cycle(input logic iv, input logic [2:0] s,
                       input logic [16:0] o, input logic c,
                       input logic ordy, input logic clr,
                       input string tag);
    bit pu, po;
    ent_t e;
    IN_VALID = iv; SEL = s; O = o; CARRY = c;
    OUT_READY = ordy; CLR_STICKY = clr;
    e = model_ent(s, o, c);
    pu = iv && (q.size() < DEPTH);
    po = ordy && (q.size() > 0);
    @(posedge CLK);
    if (po) void'(q.pop_front());
    if (pu) q.push_back(e);
    if (pu && e.flg[2]) sticky_m = 1'b1;
    else if (clr) sticky_m = 1'b0;
    #1;
    IN_VALID = 1'b0; CLR_STICKY = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset();
    IN_VALID = 1'b0; OUT_READY = 1'b0; CLR_STICKY = 1'b0;
    #2 RST_N = 1'b0;
    #2 RST_N = 1'b1;
    q.delete();
    sticky_m = 1'b0;
    @(posedge CLK); #1;
  endtask

  vec_t vt[9];

  initial begin
    vt[0] = '{3'b011, 17'h0_0000, 1'b1, 16'h0000, 3'b110, 1'b1};
    vt[1] = '{3'b000, 17'h0_8001, 1'b1, 16'h8001, 3'b001, 1'b0};
    vt[2] = '{3'b001, 17'h0_0000, 1'b1, 16'h0000, 3'b010, 1'b0};
    vt[3] = '{3'b010, 17'h1_0000, 1'b1, 16'h0000, 3'b010, 1'b0};
    vt[4] = '{3'b100, 17'h0_ffff, 1'b1, 16'hffff, 3'b101, 1'b1};
    vt[5] = '{3'b111, 17'h0_1234, 1'b0, 16'h1234, 3'b000, 1'b0};
    vt[6] = '{3'b101, 17'h1_8000, 1'b1, 16'h8000, 3'b101, 1'b1};
    vt[7] = '{3'b110, 17'h0_0000, 1'b0, 16'h0000, 3'b010, 1'b0};
    vt[8] = '{3'b011, 17'h0_7fff, 1'b0, 16'h7fff, 3'b000, 1'b0};

    q.delete();
    sticky_m = 1'b0;
    #12 RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("reset out_valid", 32'(OUT_VALID), 0);
    chk("reset in_ready", 32'(IN_READY), 1);
    chk("reset count", 32'(COUNT), 0);
    chk("reset head", 32'({RES, OUT_SEL, FLAGS}), 0);
    chk("reset sticky", 32'(STICKY_C), 0);

    // Flag derivation table, one push from reset each.
    for (int i = 0; i < 9; i++) begin
      do_reset();
      cycle(1'b1, vt[i].sel, vt[i].o, vt[i].carry, 1'b0, 1'b0, "vec");
      chk($sformatf("vec%0d valid", i), 32'(OUT_VALID), 1);
      chk($sformatf("vec%0d res", i), 32'(RES), 32'(vt[i].exp_res));
      chk($sformatf("vec%0d sel", i), 32'(OUT_SEL), 32'(vt[i].sel));
      chk($sformatf("vec%0d flags", i), 32'(FLAGS), 32'(vt[i].exp_flg));
      chk($sformatf("vec%0d sticky", i), 32'(STICKY_C),
          32'(vt[i].exp_sticky));
      chk($sformatf("vec%0d count", i), 32'(COUNT), 1);
    end

    // Fill to full, drop a fifth push, drain in order.
    do_reset();
    for (int i = 1; i <= 4; i++)
      cycle(1'b1, 3'b000, 17'(i), 1'b0, 1'b0, 1'b0, "fill");
    chk("full count", 32'(COUNT), 4);
    chk("full in_ready", 32'(IN_READY), 0);
    cycle(1'b1, 3'b000, 17'h5, 1'b0, 1'b0, 1'b0, "drop");
    chk("drop count", 32'(COUNT), 4);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("order%0d", i), 32'(RES), i);
      cycle(1'b0, 3'b000, 17'h0, 1'b0, 1'b1, 1'b0, "drain");
    end
    chk("drained count", 32'(COUNT), 0);
    chk("drained valid", 32'(OUT_VALID), 0);
    cycle(1'b0, 3'b000, 17'h0, 1'b0, 1'b1, 1'b0, "empty pop");

    // Streaming push+pop across pointer wrap.
    for (int j = 0; j < 10; j++) begin
      cycle(1'b1, 3'b001, 17'(16'h0100 + j), 1'b0, 1'b1, 1'b0, "stream");
      chk($sformatf("stream res%0d", j), 32'(RES), 32'h100 + j);
      chk($sformatf("stream count%0d", j), 32'(COUNT), 1);
    end
    cycle(1'b0, 3'b000, 17'h0, 1'b0, 1'b1, 1'b0, "stream end");

    // Sticky: set beats same-cycle clear, then clear alone.
    cycle(1'b1, 3'b100, 17'h0_0042, 1'b1, 1'b1, 1'b1, "set+clr");
    chk("sticky set wins", 32'(STICKY_C), 1);
    cycle(1'b0, 3'b000, 17'h0, 1'b0, 1'b1, 1'b1, "clr");
    chk("sticky cleared", 32'(STICKY_C), 0);

    // Async reset mid-cycle with three entries held.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 3'b011, 17'h0_0007, 1'b1, 1'b0, 1'b0, "pre-rst");
    chk("pre-rst count", 32'(COUNT), 3);
    #2 RST_N = 1'b0;
    #1;
    chk("async rst valid", 32'(OUT_VALID), 0);
    chk("async rst count", 32'(COUNT), 0);
    chk("async rst in_ready", 32'(IN_READY), 1);
    chk("async rst sticky", 32'(STICKY_C), 0);
    q.delete();
    sticky_m = 1'b0;
    #1 RST_N = 1'b1;
    @(posedge CLK); #1;
    check_all("post-rst");

    // Randomized traffic against the queue model.
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            17'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 7) == 0), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
